// File: rtl/serial_adder_core.sv
// Bit-serial add/subtract core: one operand bit per clock, LSB first, registered results.
// Define SERIAL_ADDER_SUBTRACT_EN to let op=1 select subtraction; otherwise every operation is an add.
module serial_adder_core #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s_out,
  output logic             c_out,
  output logic             ovf_out
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, acc, acc_nxt;
  logic [IDX_W-1:0] idx;
  logic             carry, carry_nxt, sum_bit;
  logic             accept, last_bit, sub_sel;

`ifdef SERIAL_ADDER_SUBTRACT_EN
  assign sub_sel = op;
`else
  logic unused_op;
  assign unused_op = op;
  assign sub_sel   = 1'b0;
`endif

  assign accept   = start && (state != BUSY);
  assign last_bit = (state == BUSY) && (idx == IDX_W'(WIDTH - 1));
  assign busy     = (state == BUSY);
  assign done     = (state == DONE);

  always_comb begin
    sum_bit      = a_reg[idx] ^ b_reg[idx] ^ carry;
    carry_nxt    = (a_reg[idx] & b_reg[idx]) | (a_reg[idx] & carry) | (b_reg[idx] & carry);
    acc_nxt      = acc;
    acc_nxt[idx] = sum_bit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction stores ~in_b and seeds carry with 1, so the bit loop is always a plain add.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      idx     <= '0;
      carry   <= 1'b0;
      s_out   <= '0;
      c_out   <= 1'b0;
      ovf_out <= 1'b0;
    end else if (accept) begin
      a_reg <= in_a;
      b_reg <= sub_sel ? ~in_b : in_b;
      carry <= sub_sel;
      acc   <= '0;
      idx   <= '0;
    end else if (state == BUSY) begin
      acc   <= acc_nxt;
      carry <= carry_nxt;
      idx   <= idx + IDX_W'(1);
      if (last_bit) begin
        s_out   <= acc_nxt;
        c_out   <= carry_nxt;
        ovf_out <= carry ^ carry_nxt;
      end
    end
  end

endmodule
